// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, FSM state encodings and the access-size mask helper
// shared by the load/store unit and its lane-alignment logic.
package lsu_pkg;

  // RV32I load/store funct3 encodings (stores use the B/H/W codes)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Controller FSM states
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ACC0 = 3'd1;
  localparam logic [2:0] ST_ACC1 = 3'd2;
  localparam logic [2:0] ST_RESP = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  // Right-aligned byte mask covering the bytes of one access
  function automatic logic [3:0] sizeMask(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_dmem_ctrl_if.sv
// lsu_dmem_ctrl_if: request/response handshake and SRAM port of the LSU.
// The slave modport is the LSU itself; the master modport is its environment
// (datapath driving requests plus the SRAM returning read data).
interface lsu_dmem_ctrl_if #(
  parameter int ADDR_W = 10
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;

  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the LSU.
// Stores are placed into a 64-bit two-word window so an access that crosses a
// word boundary can be written as a low-word part and a high-word part.
// Loads are shifted down from a two-word window and sign/zero extended.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  byteOff_i,
  input  logic        hiHalf_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdataLo_i,
  input  logic [31:0] rdataHi_i,
  output logic [3:0]  we_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  laneMask;
  logic [63:0] laneData;
  logic [31:0] loadShift;

  // Shift store enables/data into lanes and pick the low or high word half
  always_comb begin
    laneMask = {4'b0000, sizeMask(funct3_i)} << byteOff_i;
    laneData = {32'd0, wdata_i} << {byteOff_i, 3'b000};
    we_o     = hiHalf_i ? laneMask[7:4] : laneMask[3:0];
    wdata_o  = hiHalf_i ? laneData[63:32] : laneData[31:0];
  end

  // Bring the addressed bytes down to lane 0 and extend them per funct3
  always_comb begin
    loadShift = 32'({rdataHi_i, rdataLo_i} >> {byteOff_i, 3'b000});
    case (funct3_i)
      F3_B:    rdata_o = {{24{loadShift[7]}}, loadShift[7:0]};
      F3_H:    rdata_o = {{16{loadShift[15]}}, loadShift[15:0]};
      F3_W:    rdata_o = loadShift;
      F3_BU:   rdata_o = {24'd0, loadShift[7:0]};
      F3_HU:   rdata_o = {16'd0, loadShift[15:0]};
      default: rdata_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// lsu_dmem_ctrl: RV32I load/store unit driving a single-port synchronous SRAM.
// One request per valid/ready handshake; a one-cycle response pulse reports
// the extended load data or an error (illegal funct3, out of range, misaligned).
// Optional build macro LSU_MISALIGN_SPLIT_EN: word-crossing misaligned accesses
// are split into two SRAM accesses instead of being rejected.
module lsu_dmem_ctrl
  import lsu_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic             clk,
  input logic             rst,
  lsu_dmem_ctrl_if.slave  bus
);

  localparam logic [32:0] RANGE_BYTES = 33'd4 << ADDR_W;

  logic [2:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        byteOff_q, byteOff_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              memEn_q, memEn_d;
  logic [3:0]        memWe_q, memWe_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [31:0]       memWdata_q, memWdata_d;
  logic              rspValid_q, rspValid_d;
  logic              rspErr_q, rspErr_d;
  logic [31:0]       rspRdata_q, rspRdata_d;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic              split_q, split_d;
  logic [31:0]       loWord_q, loWord_d;
  logic              crossing;
`else
  logic              misaligned;
`endif

  logic        reqReady;
  logic        accept;
  logic [31:0] off;
  logic [2:0]  sizeBytes;
  logic [32:0] lastByte;
  logic        outOfRange;
  logic        legalF3;
  logic        reqErr;

  logic [2:0]  alignF3;
  logic [1:0]  alignOff;
  logic [31:0] alignWdataIn;
  logic [31:0] alignRdLo;
  logic [31:0] alignRdHi;
  logic [3:0]  alignWe;
  logic [31:0] alignWdata;
  logic [31:0] alignRdata;

  assign reqReady = (state_q == ST_IDLE) && !rst;
  assign accept   = bus.req_valid && reqReady;

  assign off        = bus.req_addr - BASE_ADDR;
  assign lastByte   = {1'b0, off} + {30'd0, sizeBytes - 3'd1};
  assign outOfRange = lastByte >= RANGE_BYTES;

  // Number of bytes touched by the incoming request
  always_comb begin
    case (bus.req_funct3[1:0])
      2'b00:   sizeBytes = 3'd1;
      2'b01:   sizeBytes = 3'd2;
      default: sizeBytes = 3'd4;
    endcase
  end

  // Unsigned load encodings are reserved when used as stores
  always_comb begin
    case (bus.req_funct3)
      F3_B, F3_H, F3_W: legalF3 = 1'b1;
      F3_BU, F3_HU:     legalF3 = !bus.req_we;
      default:          legalF3 = 1'b0;
    endcase
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  assign crossing = ({1'b0, off[1:0]} + sizeBytes) > 3'd4;
  assign reqErr   = !legalF3 || outOfRange;
`else
  assign misaligned = ((bus.req_funct3[1:0] == 2'b01) && off[0]) ||
                      ((bus.req_funct3[1:0] == 2'b10) && (off[1:0] != 2'b00));
  assign reqErr     = !legalF3 || outOfRange || misaligned;
`endif

  // Lane logic sees the live request while idle, the latched one afterwards
  assign alignF3      = (state_q == ST_IDLE) ? bus.req_funct3 : funct3_q;
  assign alignOff     = (state_q == ST_IDLE) ? off[1:0] : byteOff_q;
  assign alignWdataIn = (state_q == ST_IDLE) ? bus.req_wdata : wdata_q;
`ifdef LSU_MISALIGN_SPLIT_EN
  assign alignRdLo = split_q ? loWord_q : bus.mem_rdata;
  assign alignRdHi = split_q ? bus.mem_rdata : 32'd0;
`else
  assign alignRdLo = bus.mem_rdata;
  assign alignRdHi = 32'd0;
`endif

  lsu_align u_align (
    .funct3_i  (alignF3),
    .byteOff_i (alignOff),
    .hiHalf_i  (state_q == ST_ACC0),
    .wdata_i   (alignWdataIn),
    .rdataLo_i (alignRdLo),
    .rdataHi_i (alignRdHi),
    .we_o      (alignWe),
    .wdata_o   (alignWdata),
    .rdata_o   (alignRdata)
  );

  // Next state and next values of every registered output
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    byteOff_d  = byteOff_q;
    wdata_d    = wdata_q;
    memEn_d    = 1'b0;
    memWe_d    = 4'b0000;
    memAddr_d  = '0;
    memWdata_d = 32'd0;
    rspValid_d = 1'b0;
    rspErr_d   = 1'b0;
    rspRdata_d = 32'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
    split_d    = split_q;
    loWord_d   = loWord_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d      = bus.req_we;
          funct3_d  = bus.req_funct3;
          byteOff_d = off[1:0];
          wdata_d   = bus.req_wdata;
`ifdef LSU_MISALIGN_SPLIT_EN
          split_d   = crossing;
`endif
          if (reqErr) begin
            state_d = ST_ERR;
          end else begin
            state_d   = ST_ACC0;
            memEn_d   = 1'b1;
            memAddr_d = off[ADDR_W+1:2];
            if (bus.req_we) begin
              memWe_d    = alignWe;
              memWdata_d = alignWdata;
            end
          end
        end
      end
      ST_ACC0: begin
        state_d = ST_RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
        if (split_q) begin
          state_d   = ST_ACC1;
          memEn_d   = 1'b1;
          memAddr_d = memAddr_q + 1'b1;
          if (we_q) begin
            memWe_d    = alignWe;
            memWdata_d = alignWdata;
          end
        end
`endif
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      ST_ACC1: begin
        loWord_d = bus.mem_rdata;
        state_d  = ST_RESP;
      end
`endif
      ST_RESP: begin
        state_d    = ST_IDLE;
        rspValid_d = 1'b1;
        rspRdata_d = we_q ? 32'd0 : alignRdata;
      end
      ST_ERR: begin
        state_d    = ST_IDLE;
        rspValid_d = 1'b1;
        rspErr_d   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, request latch and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      funct3_q   <= 3'd0;
      byteOff_q  <= 2'd0;
      wdata_q    <= 32'd0;
      memEn_q    <= 1'b0;
      memWe_q    <= 4'b0000;
      memAddr_q  <= '0;
      memWdata_q <= 32'd0;
      rspValid_q <= 1'b0;
      rspErr_q   <= 1'b0;
      rspRdata_q <= 32'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q    <= 1'b0;
      loWord_q   <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      funct3_q   <= funct3_d;
      byteOff_q  <= byteOff_d;
      wdata_q    <= wdata_d;
      memEn_q    <= memEn_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      rspValid_q <= rspValid_d;
      rspErr_q   <= rspErr_d;
      rspRdata_q <= rspRdata_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q    <= split_d;
      loWord_q   <= loWord_d;
`endif
    end
  end

  assign bus.req_ready = reqReady;
  assign bus.mem_en    = memEn_q;
  assign bus.mem_we    = memWe_q;
  assign bus.mem_addr  = memAddr_q;
  assign bus.mem_wdata = memWdata_q;
  assign bus.rsp_valid = rspValid_q;
  assign bus.rsp_err   = rspErr_q;
  assign bus.rsp_rdata = rspRdata_q;

endmodule
